nway_cache_memory: RTL and testbench

Parametrised N-way set-associative cache storage array with tree-PLRU replacement, generalising the 4-way array to any power-of-two associativity. It sits under the unchanged cache controller: it keeps the same enable-driven read, write, refill and write-back operations. New in this block: asynchronous reset of the state bits, victim tag export for write-back addressing, and a hardware flush engine that walks every line and writes back dirty blocks over a valid/ready handshake.

---
 rtl/nway_cache_memory.sv | 236 +++++++++++++++++++++++
 tb/tb_nway_cache_memory.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nway_cache_memory.sv
// nway_cache_memory: N-way set-associative cache array with tree-PLRU, victim tag export and a flush engine.
// Optional hit/miss statistics under `define CACHE_STATS_EN.  Rev 1.0
`default_nettype none

module nway_cache_memory #(
  parameter int WORD_SIZE       = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int BLOCK_SIZE      = WORDS_PER_BLOCK * WORD_SIZE,
  parameter int NUM_BLOCKS      = 64,
  parameter int NUM_WAYS        = 4,
  parameter int NUM_SETS        = NUM_BLOCKS / NUM_WAYS,
  parameter int TAG_WIDTH       = 25,
  parameter int INDEX_WIDTH     = $clog2(NUM_SETS),
  parameter int OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK),
  parameter int WAY_WIDTH       = $clog2(NUM_WAYS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TAG_WIDTH-1:0]    tag,
  input  logic [INDEX_WIDTH-1:0]  index,
  input  logic [OFFSET_WIDTH-1:0] blk_offset,
  input  logic                    req_type,
  input  logic                    read_en_cache,
  input  logic                    write_en_cache,
  input  logic                    read_en_mem,
  input  logic                    write_en_mem,
  input  logic [BLOCK_SIZE-1:0]   data_in_mem,
  input  logic [WORD_SIZE-1:0]    data_in,
  output logic                    hit,
  output logic                    dirty_bit,
  output logic [WAY_WIDTH-1:0]    victim_way,
  output logic [WORD_SIZE-1:0]    data_out,
  output logic [BLOCK_SIZE-1:0]   dirty_block_out,
  output logic [TAG_WIDTH-1:0]    dirty_tag_out,
  input  logic                    flush_req,
  output logic                    flush_busy,
  output logic                    flush_done,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [BLOCK_SIZE-1:0]   wb_block,
  output logic [TAG_WIDTH-1:0]    wb_tag,
  output logic [INDEX_WIDTH-1:0]  wb_index
`ifdef CACHE_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam logic [WAY_WIDTH-1:0]   c_last_way = WAY_WIDTH'(NUM_WAYS - 1);
  localparam logic [INDEX_WIDTH-1:0] c_last_set = INDEX_WIDTH'(NUM_SETS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB_WAIT, S_DONE} flush_state_t;
  flush_state_t r_state, w_state_nxt;

  logic [NUM_WAYS-1:0]   r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0]   r_dirty [NUM_SETS];
  logic [NUM_WAYS-1:1]   r_plru  [NUM_SETS];
  logic [TAG_WIDTH-1:0]  r_tag   [NUM_SETS][NUM_WAYS];
  logic [BLOCK_SIZE-1:0] r_data  [NUM_SETS][NUM_WAYS];

  logic [INDEX_WIDTH-1:0] r_scan_set;
  logic [WAY_WIDTH-1:0]   r_scan_way;

  logic                 w_hit, w_has_inv, w_victim_dirty;
  logic [WAY_WIDTH-1:0] w_hit_way, w_inv_way, w_plru_way, w_victim, w_touch_way;
  logic [WAY_WIDTH:0]   w_node;
  logic                 w_ops_en, w_rd_hit, w_wr_hit, w_evict, w_refill, w_do_refill, w_touch;
  logic                 w_scan_dirty, w_last, w_advance;

  // Each visited node is set to point at the subtree the accessed way is not in.
  function automatic logic [NUM_WAYS-1:1] f_plru_touch(input logic [NUM_WAYS-1:1] bits,
                                                       input logic [WAY_WIDTH-1:0] way);
    logic [NUM_WAYS-1:1] res;
    logic [WAY_WIDTH:0]  node;
    res  = bits;
    node = (WAY_WIDTH+1)'(1);
    for (int l = WAY_WIDTH - 1; l >= 0; l--) begin
      res[node] = ~way[l];
      node      = {node[WAY_WIDTH-1:0], way[l]};
    end
    return res;
  endfunction

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (r_valid[index][i] && (r_tag[index][i] == tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_WIDTH'(i);
      end
    end
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!r_valid[index][i]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_WIDTH'(i);
      end
    end
    // Leaf reached by the walk is node NUM_WAYS+way, so its low bits are the way.
    w_node = (WAY_WIDTH+1)'(1);
    for (int l = 0; l < WAY_WIDTH; l++) begin
      w_node = {w_node[WAY_WIDTH-1:0], r_plru[index][w_node]};
    end
    w_plru_way     = w_node[WAY_WIDTH-1:0];
    w_victim       = w_has_inv ? w_inv_way : w_plru_way;
    w_victim_dirty = r_valid[index][w_victim] & r_dirty[index][w_victim];
  end

  assign hit        = w_hit;
  assign victim_way = w_victim;
  assign dirty_bit  = w_hit ? r_dirty[index][w_hit_way] : w_victim_dirty;

  assign w_ops_en    = (r_state == S_IDLE);
  assign w_rd_hit    = w_ops_en & w_hit & ~req_type & read_en_cache;
  assign w_wr_hit    = w_ops_en & w_hit & req_type & write_en_cache;
  assign w_evict     = w_ops_en & ~w_hit & read_en_cache & write_en_mem;
  assign w_refill    = w_ops_en & ~w_hit & read_en_mem & write_en_cache & ~w_evict;
  assign w_do_refill = w_refill & ~w_victim_dirty;
  assign w_touch     = w_rd_hit | w_wr_hit | w_do_refill;
  assign w_touch_way = w_hit ? w_hit_way : w_victim;

  assign w_scan_dirty = r_valid[r_scan_set][r_scan_way] & r_dirty[r_scan_set][r_scan_way];
  assign w_last       = (r_scan_set == c_last_set) && (r_scan_way == c_last_way);
  assign w_advance    = ((r_state == S_SCAN) & ~w_scan_dirty) | ((r_state == S_WB_WAIT) & wb_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (w_wr_hit) r_dirty[index][w_hit_way] <= 1'b1;
      if (w_evict && w_victim_dirty) r_dirty[index][w_victim] <= 1'b0;
      if (w_do_refill) begin
        r_valid[index][w_victim] <= 1'b1;
        r_dirty[index][w_victim] <= 1'b0;
      end
      if ((r_state == S_WB_WAIT) && wb_ready) r_dirty[r_scan_set][r_scan_way] <= 1'b0;
      if (w_touch) r_plru[index] <= f_plru_touch(r_plru[index], w_touch_way);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_hit) r_data[index][w_hit_way][blk_offset*WORD_SIZE +: WORD_SIZE] <= data_in;
    if (w_do_refill) begin
      r_tag[index][w_victim]  <= tag;
      r_data[index][w_victim] <= data_in_mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out        <= '0;
      dirty_block_out <= '0;
      dirty_tag_out   <= '0;
    end else begin
      data_out        <= w_rd_hit ? r_data[index][w_hit_way][blk_offset*WORD_SIZE +: WORD_SIZE] : '0;
      dirty_block_out <= (w_evict && w_victim_dirty) ? r_data[index][w_victim] : '0;
      if (w_evict && w_victim_dirty) dirty_tag_out <= r_tag[index][w_victim];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (flush_req) w_state_nxt = S_SCAN;
      S_SCAN:    if (w_scan_dirty) w_state_nxt = S_WB_WAIT;
                 else if (w_last)  w_state_nxt = S_DONE;
      S_WB_WAIT: if (wb_ready) w_state_nxt = w_last ? S_DONE : S_SCAN;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign flush_busy = (r_state != S_IDLE);
  assign flush_done = (r_state == S_DONE);
  assign wb_valid   = (r_state == S_WB_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_set <= '0;
      r_scan_way <= '0;
      wb_block   <= '0;
      wb_tag     <= '0;
      wb_index   <= '0;
    end else begin
      if ((r_state == S_IDLE) && flush_req) begin
        r_scan_set <= '0;
        r_scan_way <= '0;
      end else if (w_advance) begin
        r_scan_way <= r_scan_way + 1'b1;
        if (r_scan_way == c_last_way) r_scan_set <= r_scan_set + 1'b1;
      end
      if ((r_state == S_SCAN) && w_scan_dirty) begin
        wb_block <= r_data[r_scan_set][r_scan_way];
        wb_tag   <= r_tag[r_scan_set][r_scan_way];
        wb_index <= r_scan_set;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic w_lookup;
  assign w_lookup = w_ops_en & ~read_en_mem & ~write_en_mem &
                    ((~req_type & read_en_cache) | (req_type & write_en_cache));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stats_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (w_lookup) begin
      if (w_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_nway_cache_memory.sv
// Scoreboard bench for nway_cache_memory: stimulus queues expected responses, a monitor pops and compares.
`default_nettype none

module tb_nway_cache_memory;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [24:0]  tag;
  logic [3:0]   index;
  logic [1:0]   blk_offset;
  logic         req_type, read_en_cache, write_en_cache, read_en_mem, write_en_mem;
  logic [127:0] data_in_mem;
  logic [31:0]  data_in;
  logic         hit, dirty_bit;
  logic [1:0]   victim_way;
  logic [31:0]  data_out;
  logic [127:0] dirty_block_out;
  logic [24:0]  dirty_tag_out;
  logic         flush_req, flush_busy, flush_done, wb_valid, wb_ready;
  logic [127:0] wb_block;
  logic [24:0]  wb_tag;
  logic [3:0]   wb_index;
`ifdef CACHE_STATS_EN
  logic         stats_clr;
  logic [31:0]  hit_count, miss_count;
`endif

  nway_cache_memory dut (
    .clk(clk), .rst_n(rst_n), .tag(tag), .index(index), .blk_offset(blk_offset),
    .req_type(req_type), .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
    .read_en_mem(read_en_mem), .write_en_mem(write_en_mem), .data_in_mem(data_in_mem),
    .data_in(data_in), .hit(hit), .dirty_bit(dirty_bit), .victim_way(victim_way),
    .data_out(data_out), .dirty_block_out(dirty_block_out), .dirty_tag_out(dirty_tag_out),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_block(wb_block), .wb_tag(wb_tag),
    .wb_index(wb_index)
`ifdef CACHE_STATS_EN
    , .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] blk; logic [24:0] tg; logic [3:0] idx; } wb_t;

  logic [31:0] rd_q[$];
  wb_t         ev_q[$];
  wb_t         wb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // en = {read_en_cache, write_en_cache, read_en_mem, write_en_mem}
  task automatic op(input int t, input int ix, input int off, input logic rt, input logic [3:0] en,
                    input logic [31:0] d, input logic [127:0] blk);
    @(negedge clk);
    tag = 25'(t); index = 4'(ix); blk_offset = 2'(off); req_type = rt;
    {read_en_cache, write_en_cache, read_en_mem, write_en_mem} = en;
    data_in = d; data_in_mem = blk;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    {read_en_cache, write_en_cache, read_en_mem, write_en_mem} = 4'b0000;
    #1;
  endtask

  task automatic push_rd(input logic [31:0] v);
    rd_q.push_back(v);
  endtask

  // Monitor: observe the request a little before the edge, compare the registered response after it.
  initial begin : monitor
    logic rd_fire, ev_fire;
    wb_t  e;
    forever begin
      @(negedge clk); #3;
      rd_fire = !flush_busy && read_en_cache && !req_type && hit;
      ev_fire = !flush_busy && !hit && read_en_cache && write_en_mem && dirty_bit;
      if (wb_valid && wb_ready) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 128'(1), 128'(0));
        else begin
          e = wb_q.pop_front();
          chk("wb_index", 128'(wb_index), 128'(e.idx));
          chk("wb_tag", 128'(wb_tag), 128'(e.tg));
          chk("wb_block", wb_block, e.blk);
        end
      end
      @(posedge clk); #1;
      if (rd_fire) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 128'(1), 128'(0));
        else chk("rd_data_out", 128'(data_out), 128'(rd_q.pop_front()));
      end
      if (ev_fire) begin
        if (ev_q.size() == 0) chk("ev_unexpected", 128'(1), 128'(0));
        else begin
          e = ev_q.pop_front();
          chk("ev_block", dirty_block_out, e.blk);
          chk("ev_tag", 128'(dirty_tag_out), 128'(e.tg));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  busy_cnt, done_cnt, stall, k;
    bit  finished;
    wb_t e;
    rst_n = 1'b0; tag = '0; index = '0; blk_offset = '0; req_type = 1'b0;
    read_en_cache = 1'b0; write_en_cache = 1'b0; read_en_mem = 1'b0; write_en_mem = 1'b0;
    data_in_mem = '0; data_in = '0; flush_req = 1'b0; wb_ready = 1'b0;
`ifdef CACHE_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_data_out", 128'(data_out), 128'(0));
    chk("rst_dirty_block", dirty_block_out, 128'(0));
    chk("rst_flush_busy", 128'(flush_busy), 128'(0));
    chk("rst_wb_valid", 128'(wb_valid), 128'(0));
    @(negedge clk); rst_n = 1'b1;

    // Cold read miss
    op(5, 3, 0, 1'b0, 4'b1000, 32'h0, 128'h0);
    chk("cold_hit", 128'(hit), 128'(0));
    chk("cold_victim", 128'(victim_way), 128'(0));
    chk("cold_dirty", 128'(dirty_bit), 128'(0));
    idle();
    chk("cold_data_out", 128'(data_out), 128'(0));

    // Fill set 3, invalid ways are chosen lowest first
    for (int t = 1; t <= 4; t++) begin
      op(t, 3, 0, 1'b0, 4'b0110, 32'h0, {96'd0, 32'(t * 17)});
      chk("fill_victim", 128'(victim_way), 128'(t - 1));
    end
    idle();

    // PLRU: touch way0 -> victim 2; touch way2 -> victim 1
    op(1, 3, 0, 1'b0, 4'b1000, 32'h0, 128'h0); chk("rd1_hit", 128'(hit), 128'(1)); push_rd(32'h11);
    op(9, 3, 0, 1'b0, 4'b0000, 32'h0, 128'h0); chk("plru_victim_a", 128'(victim_way), 128'(2));
    op(3, 3, 0, 1'b0, 4'b1000, 32'h0, 128'h0); chk("rd3_hit", 128'(hit), 128'(1)); push_rd(32'h33);
    op(9, 3, 0, 1'b0, 4'b0000, 32'h0, 128'h0); chk("plru_victim_b", 128'(victim_way), 128'(1));

    // Write hit way1, steer victim back to way1, evict it
    op(2, 3, 1, 1'b1, 4'b0100, 32'hDEADBEEF, 128'h0); chk("wr_hit", 128'(hit), 128'(1));
    op(1, 3, 0, 1'b0, 4'b1000, 32'h0, 128'h0); push_rd(32'h11);
    op(3, 3, 0, 1'b0, 4'b1000, 32'h0, 128'h0); push_rd(32'h33);
    op(9, 3, 0, 1'b0, 4'b0000, 32'h0, 128'h0);
    chk("pre_ev_victim", 128'(victim_way), 128'(1));
    chk("pre_ev_dirty", 128'(dirty_bit), 128'(1));
    op(9, 3, 0, 1'b0, 4'b1001, 32'h0, 128'h0);
    e.blk = {32'd0, 32'd0, 32'hDEADBEEF, 32'h22}; e.tg = 25'd2; e.idx = 4'd3; ev_q.push_back(e);
    op(9, 3, 0, 1'b0, 4'b0000, 32'h0, 128'h0);
    chk("post_ev_dirty", 128'(dirty_bit), 128'(0));
    chk("post_ev_victim", 128'(victim_way), 128'(1));
    op(9, 3, 0, 1'b0, 4'b0110, 32'h0, {96'd0, 32'h99});
    op(9, 3, 0, 1'b0, 4'b1000, 32'h0, 128'h0); chk("refill_hit", 128'(hit), 128'(1)); push_rd(32'h99);
    idle();

    // Dirty lines in sets 0 and 5, then flush with a 3-cycle stall on the first write-back
    op(7, 0, 0, 1'b0, 4'b0110, 32'h0, {96'd0, 32'hA0});
    op(7, 0, 0, 1'b1, 4'b0100, 32'hCAFE, 128'h0);
    op(11, 5, 0, 1'b0, 4'b0110, 32'h0, {96'd0, 32'h50});
    op(11, 5, 2, 1'b1, 4'b0100, 32'h1234, 128'h0);
    idle();
    e.blk = {96'd0, 32'hCAFE}; e.tg = 25'd7; e.idx = 4'd0; wb_q.push_back(e);
    e.blk = {32'd0, 32'h1234, 32'd0, 32'h50}; e.tg = 25'd11; e.idx = 4'd5; wb_q.push_back(e);
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0; #1;
    busy_cnt = 0; done_cnt = 0; stall = 0; finished = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (flush_busy) busy_cnt++;
      if (flush_done) done_cnt++;
      if (wb_valid && stall < 3) begin
        chk("stall_wb_index", 128'(wb_index), 128'(0));
        chk("stall_wb_tag", 128'(wb_tag), 128'(7));
        stall++;
      end else if (wb_valid && stall == 3) begin
        wb_ready = 1'b1;
      end
      if (done_cnt > 0 && !flush_busy) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("flush_finished", 128'(finished), 128'(1));
    chk("flush_done_pulses", 128'(done_cnt), 128'(1));
    chk("flush_length", 128'(busy_cnt), 128'(70));
    wb_ready = 1'b0;
    op(7, 0, 0, 1'b0, 4'b0000, 32'h0, 128'h0);
    chk("post_flush_hit0", 128'(hit), 128'(1));
    chk("post_flush_dirty0", 128'(dirty_bit), 128'(0));
    op(11, 5, 0, 1'b0, 4'b0000, 32'h0, 128'h0);
    chk("post_flush_hit5", 128'(hit), 128'(1));
    chk("post_flush_dirty5", 128'(dirty_bit), 128'(0));

    // Reset while a write-back is pending
    op(7, 0, 0, 1'b1, 4'b0100, 32'h1, 128'h0);
    idle();
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0; #1;
    k = 0;
    while (!wb_valid && k < 10) begin
      @(negedge clk); #1;
      k++;
    end
    chk("abort_wb_valid_seen", 128'(wb_valid), 128'(1));
    rst_n = 1'b0; #1;
    chk("abort_busy", 128'(flush_busy), 128'(0));
    chk("abort_wb_valid", 128'(wb_valid), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    op(7, 0, 0, 1'b0, 4'b0000, 32'h0, 128'h0);
    chk("abort_line_invalid", 128'(hit), 128'(0));

`ifdef CACHE_STATS_EN
    op(3, 1, 0, 1'b0, 4'b0110, 32'h0, {96'd0, 32'h77});
    op(3, 1, 0, 1'b0, 4'b1000, 32'h0, 128'h0); push_rd(32'h77);
    op(3, 1, 0, 1'b0, 4'b1000, 32'h0, 128'h0); push_rd(32'h77);
    op(4, 1, 0, 1'b0, 4'b1000, 32'h0, 128'h0);
    idle();
    chk("stats_hits", 128'(hit_count), 128'(2));
    chk("stats_misses", 128'(miss_count), 128'(1));
    @(negedge clk); stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0; #1;
    chk("stats_clr_hits", 128'(hit_count), 128'(0));
    chk("stats_clr_misses", 128'(miss_count), 128'(0));
`endif

    repeat (3) @(negedge clk);
    chk("rd_q_drained", 128'(rd_q.size()), 128'(0));
    chk("ev_q_drained", 128'(ev_q.size()), 128'(0));
    chk("wb_q_drained", 128'(wb_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
